// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32 fetch slice: reset vector, fetch FSM states,
// and the low-opcode pattern that marks a full 32-bit instruction.
package rv32_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [1:0]  FULL_LEN_OPCODE  = 2'b11;
  localparam int          FIFO_DEPTH       = 2;

  typedef enum logic {
    ST_FETCH,
    ST_DRAIN
  } fetch_state_e;

  function automatic logic isCompressed(input logic [15:0] half);
    return half[1:0] != FULL_LEN_OPCODE;
  endfunction

endpackage

// File: rtl/rv32_mod_fetch_buffer.sv
// Two-entry word FIFO between the instruction memory and the issue logic.
// Outputs are registered so a pushed word is visible one cycle after its response.
module rv32_mod_fetch_buffer
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  logic [31:0] i_pushData,
  input  logic        i_pop,
  input  logic        i_flush,
  output logic [31:0] o_word0,
  output logic [15:0] o_word1Low,
  output logic [1:0]  o_count
);

  logic [31:0] r_word0;
  logic [31:0] r_word1;
  logic [1:0]  r_count;
  logic        w_doPop;
  logic        w_doPush;

  assign w_doPop  = i_pop && (r_count != 2'd0);
  assign w_doPush = i_push && ((r_count != 2'(FIFO_DEPTH)) || w_doPop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word0 <= '0;
      r_word1 <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      case ({w_doPush, w_doPop})
        2'b10: begin
          if (r_count == 2'd0) r_word0 <= i_pushData;
          else                 r_word1 <= i_pushData;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_word0 <= r_word1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever survives the pop.
          if (r_count == 2'd1) begin
            r_word0 <= i_pushData;
          end else begin
            r_word0 <= r_word1;
            r_word1 <= i_pushData;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_word0    = r_word0;
  assign o_word1Low = r_word1[15:0];
  assign o_count    = r_count;

endmodule

// File: rtl/rv32_mod_instruction_fetch.sv
// RV32IC instruction fetch: prefetches up to two words, splits them into 16/32-bit
// instructions for the decoder, and drops stale responses after a redirect.
module rv32_mod_instruction_fetch
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
);

  fetch_state_e r_state;
  fetch_state_e w_stateNext;
  logic [31:0]  r_pc;
  logic [29:0]  r_fetchWord;
  logic [1:0]   r_outstanding;
  logic [1:0]   r_dropCnt;
  logic         r_imemReq;

  logic [31:0]  w_word0;
  logic [15:0]  w_word1Low;
  logic [1:0]   w_count;
  logic [31:0]  w_redirPc;
  logic [15:0]  w_lowHalf;
  logic         w_upper;
  logic         w_isComp;
  logic [31:0]  w_instruction;
  logic         w_instrValid;
  logic         w_handshake;
  logic         w_leaveWord;
  logic [31:0]  w_pcNext;
  logic         w_grant;
  logic         w_rsp;
  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_outNext;
  logic [1:0]   w_countNext;
  logic [1:0]   w_dropNext;
  logic         w_reqNext;

  rv32_mod_fetch_buffer u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_pushData (imem_rdata),
    .i_pop      (w_pop),
    .i_flush    (redirect_valid),
    .o_word0    (w_word0),
    .o_word1Low (w_word1Low),
    .o_count    (w_count)
  );

  assign w_redirPc = redirect_pc & 32'hFFFF_FFFE;

  // A 32-bit instruction starting in the upper half of word0 straddles into word1.
  always_comb begin
    w_upper      = r_pc[1];
    w_lowHalf    = w_upper ? w_word0[31:16] : w_word0[15:0];
    w_isComp     = isCompressed(w_lowHalf);
    if (w_isComp)     w_instruction = {16'h0000, w_lowHalf};
    else if (w_upper) w_instruction = {w_word1Low, w_word0[31:16]};
    else              w_instruction = w_word0;
    w_instrValid = (r_state == ST_FETCH) && (w_count != 2'd0) &&
                   (!w_upper || w_isComp || (w_count == 2'(FIFO_DEPTH)));
    w_handshake  = w_instrValid && instr_ready;
    w_leaveWord  = w_upper || !w_isComp;
    w_pcNext     = r_pc + (w_isComp ? 32'd2 : 32'd4);
  end

  always_comb begin
    w_grant   = r_imemReq && imem_gnt;
    w_rsp     = imem_rvalid && (r_outstanding != 2'd0);
    w_outNext = r_outstanding;
    case ({w_grant, w_rsp})
      2'b10:   if (r_outstanding != 2'(FIFO_DEPTH)) w_outNext = r_outstanding + 2'd1;
      2'b01:   w_outNext = r_outstanding - 2'd1;
      default: w_outNext = r_outstanding;
    endcase
    w_push = w_rsp && (r_dropCnt == 2'd0) && !redirect_valid;
    w_pop  = w_handshake && w_leaveWord && !redirect_valid;
    if (redirect_valid) w_countNext = 2'd0;
    else                w_countNext = w_count + {1'b0, w_push} - {1'b0, w_pop};
  end

  // Every request still in flight at a redirect belongs to the old stream.
  always_comb begin
    w_stateNext = r_state;
    w_dropNext  = r_dropCnt;
    if (redirect_valid) begin
      w_dropNext  = w_outNext;
      w_stateNext = (w_outNext != 2'd0) ? ST_DRAIN : ST_FETCH;
    end else if (r_state == ST_DRAIN) begin
      w_dropNext  = r_dropCnt - {1'b0, w_rsp};
      w_stateNext = (w_dropNext == 2'd0) ? ST_FETCH : ST_DRAIN;
    end
    w_reqNext = (w_stateNext == ST_FETCH) &&
                (({1'b0, w_countNext} + {1'b0, w_outNext}) < 3'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_FETCH;
      r_pc          <= {RESET_PC[31:1], 1'b0};
      r_fetchWord   <= RESET_PC[31:2];
      r_outstanding <= '0;
      r_dropCnt     <= '0;
      r_imemReq     <= 1'b0;
    end else begin
      r_state       <= w_stateNext;
      r_outstanding <= w_outNext;
      r_dropCnt     <= w_dropNext;
      r_imemReq     <= w_reqNext;
      if (redirect_valid) begin
        r_pc        <= w_redirPc;
        r_fetchWord <= w_redirPc[31:2];
      end else begin
        if (w_handshake) r_pc <= w_pcNext;
        if (w_grant)     r_fetchWord <= r_fetchWord + 30'd1;
      end
    end
  end

  assign imem_req    = r_imemReq;
  assign imem_addr   = {r_fetchWord, 2'b00};
  assign instr_valid = w_instrValid;
  assign instruction = w_instruction;
  assign instr_pc    = r_pc;

endmodule

// File: tb/tb_rv32_mod_instruction_fetch.sv
// Randomized bench for the fetch unit: a behavioural memory answers requests in order
// and an instruction-stream model walks memory halfword by halfword.
module tb_rv32_mod_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  rv32_mod_instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc)
  );

  typedef struct packed {
    logic [31:0] addr;
    int          epoch;
  } pend_t;

  typedef struct {
    int          cycles;
    int          rdyPct;
    int          gntPct;
    int          rvPct;
    int          redirPct;
    int          forceAt;
    logic [31:0] forceTarget;
    int          expectOut;
    int          memSetup;
  } phase_t;

  logic [31:0] mem [0:1023];
  pend_t       pendQ[$];
  phase_t      phases[7];

  int          checks = 0;
  int          passed = 0;
  logic [31:0] modelPc;
  logic [31:0] modelFetch;
  int          outstandingTb;
  int          epoch = 0;
  int          newRsp;
  bit          awaitingFirst;
  bit          expectInvalid;
  bit          holdValid;
  logic [31:0] heldInstr;
  logic [31:0] heldPc;
  int          handshakes;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  function automatic logic [15:0] halfAt(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[11:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic int expLen(input logic [31:0] a);
    logic [15:0] h;
    h = halfAt(a);
    return (h[1:0] != 2'b11) ? 2 : 4;
  endfunction

  function automatic logic [31:0] expInstr(input logic [31:0] a);
    if (expLen(a) == 2) return {16'h0000, halfAt(a)};
    return {halfAt(a + 32'd2), halfAt(a)};
  endfunction

  task automatic setupMem(input int kind);
    logic [31:0] w;
    for (int i = 0; i < 1024; i++) begin
      w = $urandom();
      if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 1) w[17:16] = 2'b11;
      mem[i] = w;
    end
    if (kind == 1) mem[0] = 32'h0000_0513;
    if (kind == 2) mem[0] = 32'h4505_4501;
    if (kind == 3) begin
      mem[0] = {16'h0513, mem[0][15:0]};
      mem[1] = {mem[1][31:16], 16'h0000};
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    #1;
    checkOutput("rst-req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst-valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst-pc", instr_pc, 32'h0);
    checkOutput("rst-addr", imem_addr, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pendQ.delete();
    outstandingTb = 0;
    modelPc       = 32'h0;
    modelFetch    = 32'h0;
    epoch++;
    newRsp        = 0;
    awaitingFirst = 1'b1;
    expectInvalid = 1'b0;
    holdValid     = 1'b0;
    handshakes    = 0;
  endtask

  task automatic applyStimulus(input phase_t p, input int cyc);
    pend_t front;
    imem_gnt    = ($urandom_range(0, 99) < p.gntPct);
    instr_ready = ($urandom_range(0, 99) < p.rdyPct);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom();
    if (pendQ.size() > 0 && cyc >= p.forceAt && $urandom_range(0, 99) < p.rvPct) begin
      front       = pendQ[0];
      imem_rvalid = 1'b1;
      imem_rdata  = mem[front.addr[11:2]];
    end
    redirect_pc    = $urandom();
    redirect_valid = ($urandom_range(0, 99) < p.redirPct);
    if (cyc == p.forceAt) begin
      redirect_valid = 1'b1;
      redirect_pc    = p.forceTarget;
    end
  endtask

  task automatic scoreEdge(input phase_t p, input int cyc);
    pend_t front;
    pend_t item;
    int    len;
    if (cyc == p.forceAt && p.expectOut >= 0)
      checkOutput("redirect-outstanding", outstandingTb, p.expectOut);
    if (imem_rvalid) begin
      front = pendQ.pop_front();
      outstandingTb--;
      if (front.epoch == epoch) newRsp++;
    end
    if (imem_req && imem_gnt) begin
      checkOutput("fetch-addr", imem_addr, modelFetch);
      checkOutput("req-limit", {31'b0, outstandingTb < 2}, 32'd1);
      item.addr  = modelFetch;
      item.epoch = epoch;
      pendQ.push_back(item);
      outstandingTb++;
      modelFetch = modelFetch + 32'd4;
    end
    if (instr_valid && instr_ready) begin
      checkOutput("instr", instruction, expInstr(modelPc));
      checkOutput("instr-pc", instr_pc, modelPc);
      len = expLen(modelPc);
      modelPc = modelPc + len;
      awaitingFirst = 1'b0;
      handshakes++;
    end else if (instr_valid && !redirect_valid) begin
      holdValid = 1'b1;
      heldInstr = instruction;
      heldPc    = instr_pc;
    end
    if (redirect_valid) begin
      modelPc       = redirect_pc & 32'hFFFF_FFFE;
      modelFetch    = redirect_pc & 32'hFFFF_FFFC;
      epoch++;
      newRsp        = 0;
      awaitingFirst = 1'b1;
      expectInvalid = 1'b1;
      holdValid     = 1'b0;
    end
  endtask

  task automatic checkCycle();
    int need;
    if (expectInvalid) begin
      checkOutput("post-redirect-valid", {31'b0, instr_valid}, 32'd0);
      expectInvalid = 1'b0;
    end
    if (holdValid) begin
      checkOutput("stall-valid", {31'b0, instr_valid}, 32'd1);
      checkOutput("stall-instr", instruction, heldInstr);
      checkOutput("stall-pc", instr_pc, heldPc);
      holdValid = 1'b0;
    end
    if (awaitingFirst && instr_valid) begin
      need = (modelPc[1] && expLen(modelPc) == 4) ? 2 : 1;
      checkOutput("early-valid", {31'b0, newRsp >= need}, 32'd1);
    end
    if (imem_req) checkOutput("addr-align", {30'b0, imem_addr[1:0]}, 32'd0);
  endtask

  initial begin
    phases[0] = '{300,  100, 100, 100, 0, -1, 32'h0,   -1, 1};
    phases[1] = '{300,  70,  80,  70,  0, -1, 32'h0,   -1, 2};
    phases[2] = '{300,  80,  80,  60,  0, 1,  32'h2,   -1, 3};
    phases[3] = '{1500, 70,  70,  60,  3, -1, 32'h0,   -1, 0};
    phases[4] = '{300,  100, 100, 15,  0, 20, 32'h100, 2,  0};
    phases[5] = '{1500, 10,  90,  90,  2, -1, 32'h0,   -1, 0};
    phases[6] = '{2000, 60,  50,  50,  8, -1, 32'h0,   -1, 0};

    rst_n          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;

    for (int ph = 0; ph < 7; ph++) begin
      setupMem(phases[ph].memSetup);
      doReset();
      for (int cyc = 0; cyc < phases[ph].cycles; cyc++) begin
        @(negedge clk);
        checkCycle();
        applyStimulus(phases[ph], cyc);
        scoreEdge(phases[ph], cyc);
      end
      checkOutput("progress", {31'b0, handshakes > 0}, 32'd1);
      $display("[TB] phase %0d done, %0d instructions issued", ph, handshakes);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rv32_mod_instruction_fetch.md
RV32_MOD_INSTRUCTION_FETCH -- requirements
Module: rv32_mod_instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: address of the first instruction after reset.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port imem_req  output  1  word fetch request.
REQ-005 SHALL have port imem_addr  output  32  fetch address, bits[1:0] always 2'b00.
REQ-006 SHALL have port imem_gnt  input  1  request accepted this cycle (imem_req && imem_gnt).
REQ-007 SHALL have port imem_rvalid  input  1  response word valid; responses return in request order.
REQ-008 SHALL have port imem_rdata  input  32  response word, little-endian halfwords.
REQ-009 SHALL have port redirect_valid  input  1  control-flow change (branch/jump taken).
REQ-010 SHALL have port redirect_pc  input  32  new PC; bit0 ignored.
REQ-011 SHALL have port instr_valid  output  1  instruction offered to decoder.
REQ-012 SHALL have port instr_ready  input  1  decoder accepts; handshake = instr_valid && instr_ready.
REQ-013 SHALL have port instruction  output  32  32-bit instruction, or compressed halfword zero-extended to 32 bits.
REQ-014 SHALL have port instr_pc  output  32  address of offered instruction.

Function
REQ-015 SHALL hold up to 2 fetched words in a word FIFO plus pc (issue PC) and fetch_pc (next word to request).
REQ-016 SHALL assert imem_req when state is FETCH and (FIFO occupancy + outstanding requests) < 2; imem_addr = fetch_pc.
REQ-017 SHALL advance fetch_pc by 4 and increment outstanding on each grant; decrement outstanding on each imem_rvalid.
REQ-018 SHALL push imem_rdata into the FIFO on imem_rvalid when no responses remain to be dropped.
REQ-019 pc[1]=0: SHALL offer word0[15:0] zero-extended when word0[1:0]!=2'b11, else all of word0; valid once word0 present.
REQ-020 pc[1]=1: SHALL offer word0[31:16] zero-extended when word0[17:16]!=2'b11, else {word1[15:0], word0[31:16]}; valid only once word1 is present in the 32-bit case.
REQ-021 SHALL on handshake advance pc by 2 (compressed) or 4, and pop word0 when the new pc leaves word0.
REQ-022 SHALL keep instruction and instr_pc stable while instr_valid && !instr_ready.
REQ-023 Latency: first instr_valid SHALL rise no earlier than the cycle after the first imem_rvalid (registered FIFO output).
REQ-024 SHALL on redirect_valid: flush FIFO, set pc=redirect_pc with bit0 cleared, fetch_pc={redirect_pc[31:2],2'b00}, drop_cnt = outstanding after this cycle's grant/response; instr_valid SHALL be 0 the next cycle.
REQ-025 FSM states: FETCH (normal) and DRAIN (drop_cnt>0, imem_req=0); FETCH->DRAIN on redirect with drop_cnt>0; DRAIN discards each imem_rvalid and decrements drop_cnt; DRAIN->FETCH when drop_cnt reaches 0; redirect in DRAIN reloads pc/fetch_pc and keeps draining.
REQ-026 Simultaneous redirect and instruction handshake: the handshake SHALL count as accepted; redirect wins for all state.
REQ-027 Simultaneous redirect and imem_rvalid: that response SHALL be discarded (not pushed, not counted in drop_cnt).
REQ-028 Redirect to pc[1]=1 SHALL fetch the containing word and issue from its upper halfword.
REQ-029 Outstanding and drop counters SHALL be 2 bits and never wrap (max 2).

Reset
REQ-030 While rst_n=0: imem_req=0, instr_valid=0, FIFO empty, outstanding=0, drop_cnt=0, state=FETCH, pc=fetch_pc=RESET_PC.
REQ-031 Reset assertion mid-transaction SHALL abandon all in-flight requests; the memory side is reset by the same rst_n.

Structure
REQ-032 Shared package rv32_pkg SHALL hold RESET_PC default, the fetch FSM state enum and the compressed-detect helper constant (2'b11).
REQ-033 SHALL instantiate one sub-module rv32_mod_fetch_buffer (2-entry word FIFO with push, pop, flush, count).
REQ-034 instruction SHALL feed rv32_mod_instruction_decoder.instruction directly with no extra logic.

Verification
REQ-035 Reset release, RESET_PC=0, memory returns 32'h0000_0513 at 0 -> instr_valid with instruction 32'h0000_0513, instr_pc 0, then next request addr 4.
REQ-036 Word 0 = 32'h4505_4501 (two C.LI) -> instructions 32'h0000_4501 @0 and 32'h0000_4505 @2, one word request.
REQ-037 Word0 upper half 16'h0513, word1 lower 16'h0000, pc=2 -> 32'h0000_0513 at instr_pc 2, offered only after word1 arrives.
REQ-038 Two outstanding requests then redirect_pc=32'h100 -> both responses dropped, next imem_addr 32'h100, first instr_pc 32'h100.
REQ-039 instr_ready held 0 for 5 cycles with full FIFO -> imem_req=0, instruction/instr_pc stable, no word lost.
REQ-040 Redirect in same cycle as imem_rvalid and handshake -> response discarded, handshake counted, next instr_pc = redirect_pc.
